// File: rtl/ps2_pkg.sv
// Shared PS/2 receiver types and frame constants.
package ps2_pkg;

    localparam int PS2_FRAME_BITS = 11;
    localparam int PS2_DATA_BITS  = 8;

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PARITY,
        STOP
    } ps2_state_e;

    // True when data plus parity bit carry an odd number of ones.
    function automatic logic odd_parity_ok(input logic [PS2_DATA_BITS-1:0] data,
                                           input logic                     parity);
        return ^{data, parity};
    endfunction

endpackage

// File: rtl/ps2_sync_filter.sv
// Two-flop synchronisers for both PS/2 pins, glitch filter and fall detect on ps2clk.
module ps2_sync_filter #(
    parameter int FILTER_LEN = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic ps2clk,
    input  logic ps2data,
    output logic fall,
    output logic data_bit
);

    localparam int CW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

    logic [1:0]    clk_sync_q;
    logic [1:0]    data_sync_q;
    logic [CW-1:0] filt_cnt_q;
    logic          clk_filt_q;
    logic          clk_filt_d_q;

    // NOTE: every clocked process uses <= so all flops sample pre-edge values
    // and the synchroniser chain shifts by exactly one stage per clock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_sync_q  <= 2'b11;
            data_sync_q <= 2'b11;
        end else begin
            clk_sync_q  <= {clk_sync_q[0], ps2clk};
            data_sync_q <= {data_sync_q[0], ps2data};
        end
    end

    // The filtered clock only follows the pin after FILTER_LEN differing samples in a row.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            filt_cnt_q   <= '0;
            clk_filt_q   <= 1'b1;
            clk_filt_d_q <= 1'b1;
        end else begin
            clk_filt_d_q <= clk_filt_q;
            if (clk_sync_q[1] == clk_filt_q) begin
                filt_cnt_q <= '0;
            end else if (filt_cnt_q == CW'(FILTER_LEN - 1)) begin
                filt_cnt_q <= '0;
                clk_filt_q <= clk_sync_q[1];
            end else begin
                filt_cnt_q <= filt_cnt_q + 1'b1;
            end
        end
    end

    assign fall     = clk_filt_d_q & ~clk_filt_q;
    assign data_bit = data_sync_q[1];

endmodule

// File: rtl/ps2_rx_fifo.sv
// PS/2 device-to-host receiver with frame checking and a first-word fall-through FIFO.
// Define PS2_RX_TIMEOUT_EN to abort partial frames after TIMEOUT_CYCLES idle clocks.
module ps2_rx_fifo #(
    parameter int FILTER_LEN     = 4,
    parameter int FIFO_DEPTH     = 8,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              ps2clk,
    input  logic                              ps2data,
    output logic [7:0]                        code,
    output logic                              code_valid,
    input  logic                              code_ready,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_count,
    output logic                              parity_err,
    output logic                              frame_err,
    output logic                              overflow,
    output logic                              timeout_err
);

    import ps2_pkg::*;

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int BW = $clog2(PS2_DATA_BITS);

    logic fall;
    logic data_bit;

    ps2_sync_filter #(.FILTER_LEN(FILTER_LEN)) u_sync_filter (
        .clk      (clk),
        .rst_n    (rst_n),
        .ps2clk   (ps2clk),
        .ps2data  (ps2data),
        .fall     (fall),
        .data_bit (data_bit)
    );

    ps2_state_e               state_q, state_n;
    logic [BW-1:0]            bit_cnt_q, bit_cnt_n;
    logic [PS2_DATA_BITS-1:0] shift_q, shift_n;
    logic                     par_q, par_n;
    logic                     frame_err_n, parity_err_n, push_n;
    logic                     push_q;
    logic [PS2_DATA_BITS-1:0] push_data_q;
    logic                     timeout_hit;

    // NOTE: every variable driven here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_n      = state_q;
        bit_cnt_n    = bit_cnt_q;
        shift_n      = shift_q;
        par_n        = par_q;
        frame_err_n  = 1'b0;
        parity_err_n = 1'b0;
        push_n       = 1'b0;
        if (timeout_hit) begin
            state_n = IDLE;
        end else if (fall) begin
            unique case (state_q)
                IDLE: begin
                    if (!data_bit) begin
                        state_n   = DATA;
                        bit_cnt_n = '0;
                    end else begin
                        frame_err_n = 1'b1;
                    end
                end
                DATA: begin
                    shift_n   = {data_bit, shift_q[PS2_DATA_BITS-1:1]};
                    bit_cnt_n = bit_cnt_q + 1'b1;
                    if (bit_cnt_q == BW'(PS2_DATA_BITS - 1)) state_n = PARITY;
                end
                PARITY: begin
                    par_n   = data_bit;
                    state_n = STOP;
                end
                STOP: begin
                    state_n = IDLE;
                    if (!data_bit)                         frame_err_n  = 1'b1;
                    else if (!odd_parity_ok(shift_q, par_q)) parity_err_n = 1'b1;
                    else                                   push_n       = 1'b1;
                end
                default: state_n = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            par_q       <= 1'b0;
            frame_err   <= 1'b0;
            parity_err  <= 1'b0;
            push_q      <= 1'b0;
            push_data_q <= '0;
        end else begin
            state_q    <= state_n;
            bit_cnt_q  <= bit_cnt_n;
            shift_q    <= shift_n;
            par_q      <= par_n;
            frame_err  <= frame_err_n;
            parity_err <= parity_err_n;
            push_q     <= push_n;
            if (push_n) push_data_q <= shift_q;
        end
    end

`ifdef PS2_RX_TIMEOUT_EN
    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [TW-1:0] to_cnt_q;

    // A fall landing on the expiry cycle loses to the abort.
    assign timeout_hit = (state_q != IDLE) && (to_cnt_q == TW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            to_cnt_q    <= '0;
            timeout_err <= 1'b0;
        end else begin
            timeout_err <= timeout_hit;
            if (state_q == IDLE || fall || timeout_hit) to_cnt_q <= '0;
            else                                         to_cnt_q <= to_cnt_q + 1'b1;
        end
    end
`else
    logic unused_timeout_cfg;

    assign unused_timeout_cfg = |TIMEOUT_CYCLES;
    assign timeout_hit        = 1'b0;
    assign timeout_err        = 1'b0;
`endif

    logic [PS2_DATA_BITS-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]            wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]            count_q;
    logic                     full, pop, do_push;

    assign full    = (count_q == CW'(FIFO_DEPTH));
    assign pop     = code_valid & code_ready;
    assign do_push = push_q & (~full | pop);

    // NOTE: the storage array has no reset; occupancy lives in count_q and
    // code is masked while empty, so stale entries are never visible.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr_q] <= push_data_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)     rd_ptr_q <= rd_ptr_q + 1'b1;
            unique case ({do_push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    assign code_valid = (count_q != '0);
    assign code       = code_valid ? mem[rd_ptr_q] : '0;
    assign fifo_count = count_q;
    assign overflow   = push_q & full & ~pop;

endmodule

// File: tb/tb_ps2_rx_fifo.sv
// Directed bench for ps2_rx_fifo; timeout cases run when PS2_RX_TIMEOUT_EN is defined.
module tb_ps2_rx_fifo;

    localparam int FILTER_LEN     = 4;
    localparam int FIFO_DEPTH     = 8;
    localparam int TIMEOUT_CYCLES = 200;
    localparam int CW             = $clog2(FIFO_DEPTH + 1);

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          ps2clk = 1'b1;
    logic          ps2data = 1'b1;
    logic          code_ready = 1'b0;
    logic [7:0]    code;
    logic          code_valid;
    logic [CW-1:0] fifo_count;
    logic          parity_err, frame_err, overflow, timeout_err;

    always #5 clk = ~clk;

    ps2_rx_fifo #(
        .FILTER_LEN     (FILTER_LEN),
        .FIFO_DEPTH     (FIFO_DEPTH),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .ps2clk      (ps2clk),
        .ps2data     (ps2data),
        .code        (code),
        .code_valid  (code_valid),
        .code_ready  (code_ready),
        .fifo_count  (fifo_count),
        .parity_err  (parity_err),
        .frame_err   (frame_err),
        .overflow    (overflow),
        .timeout_err (timeout_err)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int n_parity = 0, n_frame = 0, n_over = 0, n_timeout = 0;
    int p0, f0, o0, t0;

    always @(negedge clk) begin
        if (parity_err)  n_parity++;
        if (frame_err)   n_frame++;
        if (overflow)    n_over++;
        if (timeout_err) n_timeout++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic snap();
        p0 = n_parity; f0 = n_frame; o0 = n_over; t0 = n_timeout;
    endtask

    function automatic logic odd_par(input logic [7:0] d);
        return ~^d;
    endfunction

    task automatic ps2_bit(input logic b);
        ps2data = b;
        wait_clks(10);
        ps2clk = 1'b0;
        wait_clks(20);
        ps2clk = 1'b1;
        wait_clks(10);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic par, input logic stop, input int nbits);
        logic [10:0] f;
        f = {stop, par, d, 1'b0};
        for (int i = 0; i < nbits; i++) ps2_bit(f[i]);
        ps2data = 1'b1;
        wait_clks(20);
    endtask

    task automatic send_good(input logic [7:0] d);
        send_frame(d, odd_par(d), 1'b1, 11);
    endtask

    task automatic pop_one();
        code_ready = 1'b1;
        wait_clks(1);
        code_ready = 1'b0;
    endtask

    logic [7:0] vec [9] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h5A};

    initial begin
        wait_clks(3);
        check("rst_code",  code, 8'h00);
        check("rst_valid", code_valid, 0);
        check("rst_count", fifo_count, 0);
        check("rst_pulses", {parity_err, frame_err, overflow, timeout_err}, 0);
        rst_n = 1'b1;
        wait_clks(5);

        // Good frame 0x1C, parity 0, stop 1, consumer stalled.
        snap();
        send_good(8'h1C);
        check("t1_code",   code, 8'h1C);
        check("t1_valid",  code_valid, 1);
        check("t1_count",  fifo_count, 1);
        check("t1_errors", (n_parity - p0) + (n_frame - f0) + (n_over - o0), 0);

        // Bad parity.
        snap();
        send_frame(8'h1C, 1'b1, 1'b1, 11);
        check("t2_parity", n_parity - p0, 1);
        check("t2_frame",  n_frame - f0, 0);
        check("t2_count",  fifo_count, 1);
        check("t2_code",   code, 8'h1C);

        // Stop bit 0 with bad parity: frame error has priority.
        snap();
        send_frame(8'h1C, 1'b1, 1'b0, 11);
        check("t3_frame",  n_frame - f0, 1);
        check("t3_parity", n_parity - p0, 0);
        check("t3_count",  fifo_count, 1);

        // Start bit 1 while idle.
        snap();
        ps2_bit(1'b1);
        wait_clks(20);
        check("t3b_frame", n_frame - f0, 1);
        check("t3b_count", fifo_count, 1);

        pop_one();
        check("drain_count", fifo_count, 0);
        check("drain_valid", code_valid, 0);
        check("drain_code",  code, 8'h00);

        // Overflow: FIFO_DEPTH+1 good frames with no consumer.
        snap();
        for (int i = 0; i < FIFO_DEPTH + 1; i++) send_good(vec[i]);
        check("t4_count", fifo_count, FIFO_DEPTH);
        check("t4_over",  n_over - o0, 1);
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            check($sformatf("t4_order%0d", i), code, vec[i]);
            pop_one();
        end
        check("t4_empty", fifo_count, 0);
        pop_one();
        check("t4_pop_empty", fifo_count, 0);

        // Clock glitch shorter than the filter while idle.
        snap();
        ps2clk = 1'b0;
        wait_clks(FILTER_LEN - 1);
        ps2clk = 1'b1;
        wait_clks(30);
        check("t5_frame", n_frame - f0, 0);
        send_good(8'h5A);
        check("t5_code",   code, 8'h5A);
        check("t5_count",  fifo_count, 1);
        check("t5_errors", (n_parity - p0) + (n_frame - f0), 0);
        pop_one();

        // Reset mid-frame with a byte buffered.
        send_good(8'h1C);
        send_frame(8'hAA, 1'b1, 1'b1, 5);
        rst_n = 1'b0;
        wait_clks(2);
        check("t6_rst_code",   code, 8'h00);
        check("t6_rst_valid",  code_valid, 0);
        check("t6_rst_count",  fifo_count, 0);
        check("t6_rst_pulses", {parity_err, frame_err, overflow, timeout_err}, 0);
        rst_n = 1'b1;
        wait_clks(5);
        snap();
        send_good(8'hF0);
        check("t6_code",   code, 8'hF0);
        check("t6_count",  fifo_count, 1);
        check("t6_errors", (n_parity - p0) + (n_frame - f0), 0);
        pop_one();

`ifdef PS2_RX_TIMEOUT_EN
        // Stall ps2clk after four bits; the partial frame must be abandoned.
        snap();
        send_frame(8'h55, 1'b1, 1'b1, 4);
        wait_clks(TIMEOUT_CYCLES + 20);
        check("t7_timeout", n_timeout - t0, 1);
        check("t7_frame",   n_frame - f0, 0);
        send_good(8'hF0);
        check("t7_code",  code, 8'hF0);
        check("t7_count", fifo_count, 1);
        check("t7_timeout_once", n_timeout - t0, 1);
        pop_one();
`else
        check("t7_timeout_tied", n_timeout, 0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
